// File: rtl/btn_sw_conditioner.sv
// Button/switch conditioner: 2-flop sync, per-bit debounce,
// registered levels plus press/release/change pulses.
module btn_sw_conditioner #(
  parameter int NUM_BTN   = 5,
  parameter int NUM_SW    = 8,
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_SW-1:0]  sw_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_SW-1:0]  sw_level,
  output logic               sw_change,
  output logic [NUM_SW-1:0]  sw_change_mask
);

  localparam int N = NUM_BTN + NUM_SW;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [N-1:0] raw;
  logic [N-1:0] s1_q, s1_d;
  logic [N-1:0] s2_q, s2_d;
  logic [N-1:0] stable_q, stable_d;
  logic [N-1:0] acc;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];

  logic [NUM_BTN-1:0] press_q, press_d;
  logic [NUM_BTN-1:0] release_q, release_d;
  logic               change_q, change_d;
  logic [NUM_SW-1:0]  mask_q, mask_d;

  assign raw = {sw_raw, btn_raw};

  always_comb begin
    s1_d     = raw;
    s2_d     = s1_q;
    stable_d = stable_q;
    acc      = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      // any mismatch-free cycle drops accumulated credit
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          acc[i]      = 1'b1;
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    press_d   = acc[NUM_BTN-1:0] & s2_q[NUM_BTN-1:0];
    release_d = acc[NUM_BTN-1:0] & ~s2_q[NUM_BTN-1:0];
    mask_d    = acc[N-1:NUM_BTN];
    change_d  = |mask_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      stable_q  <= '0;
      cnt_q     <= '{default: '0};
      press_q   <= '0;
      release_q <= '0;
      change_q  <= 1'b0;
      mask_q    <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      change_q  <= change_d;
      mask_q    <= mask_d;
    end
  end

  assign btn_level      = stable_q[NUM_BTN-1:0];
  assign sw_level       = stable_q[N-1:NUM_BTN];
  assign btn_press      = press_q;
  assign btn_release    = release_q;
  assign sw_change      = change_q;
  assign sw_change_mask = mask_q;

endmodule

// File: tb/tb_btn_sw_conditioner.sv
// Directed bench for btn_sw_conditioner with DB_CYCLES=4:
// level/pulse latency, glitch, bounce, reset abort.
module tb_btn_sw_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn_raw;
  logic [7:0] sw_raw;
  logic [4:0] btn_level, btn_press, btn_release;
  logic [7:0] sw_level, sw_change_mask;
  logic       sw_change;

  int checks   = 0;
  int failures = 0;

  logic [31:0] allout;
  logic [31:0] acc_v;
  int          cnt_v;

  btn_sw_conditioner #(
    .NUM_BTN(5), .NUM_SW(8), .DB_CYCLES(4), .CNT_W(3)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_raw(btn_raw), .sw_raw(sw_raw),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .sw_level(sw_level),
    .sw_change(sw_change), .sw_change_mask(sw_change_mask)
  );

  always #5 clk = ~clk;

  assign allout = {btn_level, btn_press, btn_release,
                   sw_level, sw_change, sw_change_mask};

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; btn_raw = '0; sw_raw = '0;
    step(2);
    rst = 1'b0;
    step(2);
    chk("idle_after_reset", allout, 32'h0);
  endtask

  initial begin
    // 1: reset with everything high, then initial switch capture
    rst = 1'b1; btn_raw = 5'h1F; sw_raw = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_all_zero", allout, 32'h0);
    end
    rst = 1'b0;
    step(5);
    chk("t1_btn_lvl_e5", {27'h0, btn_level}, 32'h0);
    chk("t1_sw_lvl_e5", {24'h0, sw_level}, 32'h0);
    step(1);
    chk("t1_btn_lvl_e6", {27'h0, btn_level}, 32'h1F);
    chk("t1_sw_lvl_e6", {24'h0, sw_level}, 32'hFF);
    chk("t1_sw_chg_e6", {31'h0, sw_change}, 32'h1);
    chk("t1_mask_e6", {24'h0, sw_change_mask}, 32'hFF);
    chk("t1_press_e6", {27'h0, btn_press}, 32'h1F);
    step(1);
    chk("t1_sw_chg_e7", {31'h0, sw_change}, 32'h0);
    chk("t1_mask_e7", {24'h0, sw_change_mask}, 32'h0);
    chk("t1_press_e7", {27'h0, btn_press}, 32'h0);
    chk("t1_sw_lvl_e7", {24'h0, sw_level}, 32'hFF);

    // 2: btn0 press and release latency
    do_reset();
    btn_raw = 5'h01;
    step(5);
    chk("t2_lvl_e5", {27'h0, btn_level}, 32'h0);
    chk("t2_press_e5", {27'h0, btn_press}, 32'h0);
    step(1);
    chk("t2_lvl_e6", {27'h0, btn_level}, 32'h01);
    chk("t2_press_e6", {27'h0, btn_press}, 32'h01);
    step(1);
    chk("t2_press_e7", {27'h0, btn_press}, 32'h0);
    chk("t2_lvl_e7", {27'h0, btn_level}, 32'h01);
    step(3);
    btn_raw = 5'h00;
    step(5);
    chk("t2_rel_e5", {27'h0, btn_release}, 32'h0);
    chk("t2_lvl_hold", {27'h0, btn_level}, 32'h01);
    step(1);
    chk("t2_rel_e6", {27'h0, btn_release}, 32'h01);
    chk("t2_lvl_fall", {27'h0, btn_level}, 32'h0);
    step(1);
    chk("t2_rel_e7", {27'h0, btn_release}, 32'h0);

    // 3: 3-cycle glitch rejected, 4-cycle pulse accepted
    do_reset();
    btn_raw = 5'h04;
    step(3);
    btn_raw = 5'h00;
    acc_v = '0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      acc_v |= {17'h0, btn_level, btn_press, btn_release};
    end
    chk("t3_glitch", acc_v, 32'h0);
    btn_raw = 5'h04;
    step(4);
    btn_raw = 5'h00;
    step(1);
    chk("t3_lvl_e5", {27'h0, btn_level}, 32'h0);
    step(1);
    chk("t3_lvl_e6", {27'h0, btn_level}, 32'h04);
    chk("t3_press_e6", {27'h0, btn_press}, 32'h04);
    step(4);
    chk("t3_rel_e10", {27'h0, btn_release}, 32'h04);
    chk("t3_lvl_e10", {27'h0, btn_level}, 32'h0);

    // 4: switch bounce yields a single change
    do_reset();
    cnt_v = 0;
    for (int i = 0; i < 4; i++) begin
      sw_raw = (i % 2 == 0) ? 8'h08 : 8'h00;
      repeat (2) begin
        step(1);
        if (sw_change) cnt_v++;
      end
    end
    sw_raw = 8'h08;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (sw_change) cnt_v++;
    end
    chk("t4_no_early_chg", cnt_v, 32'd0);
    step(1);
    chk("t4_chg_e6", {31'h0, sw_change}, 32'h1);
    chk("t4_mask_e6", {24'h0, sw_change_mask}, 32'h08);
    cnt_v = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (sw_change) cnt_v++;
    end
    chk("t4_no_late_chg", cnt_v, 32'd0);
    chk("t4_sw_lvl", {24'h0, sw_level}, 32'h08);

    // 5: simultaneous acceptances
    do_reset();
    btn_raw = 5'b00011;
    sw_raw  = 8'h80;
    step(6);
    chk("t5_press", {27'h0, btn_press}, 32'h03);
    chk("t5_chg", {31'h0, sw_change}, 32'h1);
    chk("t5_mask", {24'h0, sw_change_mask}, 32'h80);
    step(1);
    chk("t5_clear", {btn_press, btn_release, sw_change,
                     sw_change_mask, 13'h0}, 32'h0);

    // 6: reset aborts a count about to complete
    do_reset();
    btn_raw = 5'h02;
    step(5);
    rst = 1'b1;
    step(1);
    chk("t6_rst_press", {27'h0, btn_press}, 32'h0);
    chk("t6_rst_lvl", {27'h0, btn_level}, 32'h0);
    rst = 1'b0;
    step(5);
    chk("t6_lvl_e5", {27'h0, btn_level}, 32'h0);
    step(1);
    chk("t6_lvl_e6", {27'h0, btn_level}, 32'h02);
    chk("t6_press_e6", {27'h0, btn_press}, 32'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
